rom_arbiter: RTL and testbench

Two-port arbiter that shares one synchronous, word-addressed program ROM between the instruction-fetch port (port 0) and the data-load port (port 1) of the Reflet core. It serialises accesses, drives the ROM's enable and address, captures the registered ROM word, and returns it to the winning requester with a one-cycle acknowledge. It sits between the core's bus front-end and the ROM instance, so the ROM needs only a single read port.

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_arbiter_if.sv | 42 ++++
 rtl/rom_arb_pick.sv | 32 +++
 rtl/rom_arbiter.sv | 109 ++++++++++
 tb/tb_rom_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: constants shared by the rom_arbiter slice.
//   - FSM state encoding (one-hot): ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_ACK
//   - Port ids: PORT_FETCH (0, instruction fetch) and PORT_LOAD (1, data load)
//   - Default widths: DEF_ADDR_W = 30 (word address), DEF_DATA_W = 32 (ROM word)
// Optional feature macro used in this slice: ROM_ARB_ROUND_ROBIN_EN.
package rom_arb_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ISSUE   = 4'b0010,
        ST_CAPTURE = 4'b0100,
        ST_ACK     = 4'b1000
    } state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bus bundle between the two Reflet requesters, the arbiter
// and the single-port program ROM.
//   req0/addr0/ack0/data0 : port 0 (instruction fetch)
//   req1/addr1/ack1/data1 : port 1 (data load)
//   rom_enable/rom_addr   : arbiter -> ROM
//   rom_data              : ROM -> arbiter, registered, one cycle after rom_addr
//
// Handshake: a requester raises reqN with a stable addrN and keeps both until
// it sees ackN high for one cycle; dataN is valid in that same cycle and is
// held until the next ackN. A reqN still high in the cycle after ackN is
// treated as a new access. The arbiter never asserts ack0 and ack1 together.
//
// Modports: slave = arbiter side, master = requesters + ROM side.
interface rom_arbiter_if import rom_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic [DATA_W-1:0] data0;

    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] data1;

    logic              rom_enable;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output ack0, data0, ack1, data1, rom_enable, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  ack0, data0, ack1, data1, rom_enable, rom_addr
    );

endinterface

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational winner select for the ROM arbiter.
//   req0, req1  : current request levels
//   last        : last granted port (only present with ROM_ARB_ROUND_ROBIN_EN)
//   grant_valid : at least one port is requesting
//   grant_id    : winning port id (PORT_FETCH / PORT_LOAD)
// Macro ROM_ARB_ROUND_ROBIN_EN: defined -> round-robin on ties (the port that
// was not granted last wins); undefined -> fixed priority, port 0 wins ties.
module rom_arb_pick import rom_arb_pkg::*; (
    input  logic req0,
    input  logic req1,
`ifdef ROM_ARB_ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT_FETCH;
        if (req0 && req1) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            grant_id = ~last;
`else
            grant_id = PORT_FETCH;
`endif
        end else if (req1) begin
            grant_id = PORT_LOAD;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous word-addressed program ROM between the
// instruction-fetch port (0) and the data-load port (1).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   bus       : rom_arbiter_if.slave (requester ports and ROM port)
//   dbg_state : current FSM state (one-hot)
// Access sequence: IDLE (grant, latch address) -> ISSUE (ROM samples address)
// -> CAPTURE (ROM word valid, registered into dataN) -> ACK (ackN high).
// Macro ROM_ARB_ROUND_ROBIN_EN: defined -> round-robin using the `last`
// register; undefined -> fixed priority to port 0 and `last` is not built.
module rom_arbiter import rom_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    rom_arbiter_if.slave bus,
    output state_t       dbg_state
);

    state_t            state;
    logic              owner;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] data0_q;
    logic [DATA_W-1:0] data1_q;
    logic              rom_enable_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              grant_valid;
    logic              grant_id;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic              last;
`endif

    rom_arb_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
`ifdef ROM_ARB_ROUND_ROBIN_EN
        .last        (last),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            owner        <= PORT_FETCH;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            rom_enable_q <= 1'b0;
            rom_addr_q   <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            // Port 1 counts as granted last so port 0 wins the first tie.
            last         <= PORT_LOAD;
`endif
        end else begin
            // Acks are set only in CAPTURE, so they are high for the ACK cycle alone.
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        rom_addr_q   <= (grant_id == PORT_LOAD) ? bus.addr1 : bus.addr0;
                        owner        <= grant_id;
                        rom_enable_q <= 1'b1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                        last         <= grant_id;
`endif
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rom_enable_q <= 1'b0;
                    if (owner == PORT_LOAD) begin
                        data1_q <= bus.rom_data;
                        ack1_q  <= 1'b1;
                    end else begin
                        data0_q <= bus.rom_data;
                        ack0_q  <= 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    // Requests are ignored here; a held request is a new access in IDLE.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.data0      = data0_q;
    assign bus.data1      = data1_q;
    assign bus.rom_enable = rom_enable_q;
    assign bus.rom_addr   = rom_addr_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter.
// Contains a registered ROM model, scenario tasks with inline checks, and a
// transaction-level scoreboard: each cycle in which the arbiter is free and a
// request is present produces an expected ack 3 cycles later carrying the ROM
// word of the chosen address; rom_enable is expected in the two cycles after
// a grant. Follows ROM_ARB_ROUND_ROBIN_EN for the arbitration rule.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int EW = 32 + 1 + DW;

    logic   clk = 1'b0;
    logic   reset;
    state_t dbg_state;

    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ROM model ----------------
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            30'h00:  rom_word = 32'h4D525341;
            30'h0F:  rom_word = 32'hABCDEF00;
            30'h17:  rom_word = 32'h01020304;
            30'h1F:  rom_word = 32'h000000FB;
            default: rom_word = '0;
        endcase
    endfunction

    always @(posedge clk) bus.rom_data <= bus.rom_enable ? rom_word(bus.rom_addr) : '0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] m_d0    = '0;
    logic [DW-1:0] m_d1    = '0;
    logic [AW-1:0] m_raddr = '0;
    int            m_next  = 0;
    int            m_gcyc  = -10;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic          m_last  = 1'b1;
`endif

    always @(negedge clk) begin : scoreboard
        logic          e_a0, e_a1, e_en, win;
        logic [EW-1:0] e;
        logic [AW-1:0] a;
        if (reset !== 1'b1) begin
            checks++;
            if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.rom_enable !== 1'b0 ||
                bus.data0 !== '0 || bus.data1 !== '0 || bus.rom_addr !== '0) begin
                failures++;
                $display("FAIL sb_reset_outputs: ack0=%b ack1=%b en=%b data0=%h data1=%h rom_addr=%h, required all 0",
                         bus.ack0, bus.ack1, bus.rom_enable, bus.data0, bus.data1, bus.rom_addr);
            end
            exp_q.delete();
            m_d0 = '0; m_d1 = '0; m_raddr = '0;
            m_next = cyc; m_gcyc = -10;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            m_last = 1'b1;
`endif
        end else begin
            e_a0 = 1'b0;
            e_a1 = 1'b0;
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (int'(e[EW-1:DW+1]) == cyc) begin
                    void'(exp_q.pop_front());
                    if (e[DW]) begin e_a1 = 1'b1; m_d1 = e[DW-1:0]; end
                    else       begin e_a0 = 1'b1; m_d0 = e[DW-1:0]; end
                end
            end
            e_en = (cyc == m_gcyc + 1) || (cyc == m_gcyc + 2);
            checks++;
            if (bus.ack0 !== e_a0) begin
                failures++; $display("FAIL sb_ack0 cyc=%0d: got %b want %b", cyc, bus.ack0, e_a0);
            end
            checks++;
            if (bus.ack1 !== e_a1) begin
                failures++; $display("FAIL sb_ack1 cyc=%0d: got %b want %b", cyc, bus.ack1, e_a1);
            end
            checks++;
            if (bus.data0 !== m_d0) begin
                failures++; $display("FAIL sb_data0 cyc=%0d: got %h want %h", cyc, bus.data0, m_d0);
            end
            checks++;
            if (bus.data1 !== m_d1) begin
                failures++; $display("FAIL sb_data1 cyc=%0d: got %h want %h", cyc, bus.data1, m_d1);
            end
            checks++;
            if (bus.rom_enable !== e_en) begin
                failures++; $display("FAIL sb_rom_enable cyc=%0d: got %b want %b", cyc, bus.rom_enable, e_en);
            end
            checks++;
            if (bus.rom_addr !== m_raddr) begin
                failures++; $display("FAIL sb_rom_addr cyc=%0d: got %h want %h", cyc, bus.rom_addr, m_raddr);
            end
            // A free arbiter grants whatever is requested this cycle.
            if (cyc >= m_next && (bus.req0 === 1'b1 || bus.req1 === 1'b1)) begin
                if (bus.req0 === 1'b1 && bus.req1 === 1'b1) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
                    win = ~m_last;
`else
                    win = 1'b0;
`endif
                end else begin
                    win = (bus.req1 === 1'b1);
                end
                a = win ? bus.addr1 : bus.addr0;
                exp_q.push_back({32'(cyc + 3), win, rom_word(a)});
                m_raddr = a;
                m_gcyc  = cyc;
                m_next  = cyc + 4;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                m_last  = win;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One access on one port; cycle i=0 is the cycle req is first visible.
    // Request is dropped in cycle 4 (the IDLE after ACK).
    task automatic run_access(input bit port, input logic [AW-1:0] addr,
                              input int chg_at, input logic [AW-1:0] chg_addr,
                              output int ack_at, output int ack_cnt, output int en_cnt,
                              output int other_cnt, output logic [DW-1:0] data);
        ack_at = -1; ack_cnt = 0; en_cnt = 0; other_cnt = 0; data = 'x;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if (port) begin bus.req1 = 1'b1; bus.addr1 = addr; end
                else      begin bus.req0 = 1'b1; bus.addr0 = addr; end
            end
            if (i == chg_at) begin
                if (port) bus.addr1 = chg_addr; else bus.addr0 = chg_addr;
            end
            if (i == 4) begin
                if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
            end
            @(negedge clk);
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
                ack_cnt++;
                if (ack_at < 0) begin
                    ack_at = i;
                    data   = port ? bus.data1 : bus.data0;
                end
            end
            if ((port ? bus.ack0 : bus.ack1) === 1'b1) other_cnt++;
            if (bus.rom_enable === 1'b1) en_cnt++;
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       pick_addr = 30'h00;
            1:       pick_addr = 30'h0F;
            2:       pick_addr = 30'h17;
            3:       pick_addr = 30'h1F;
            default: pick_addr = 30'($urandom());
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++; $display("FAIL reset_state: got %b want %b", dbg_state, ST_IDLE);
        end
        checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            failures++; $display("FAIL reset_acks: got %b%b want 00", bus.ack0, bus.ack1);
        end
        checks++;
        if (bus.data0 !== '0 || bus.data1 !== '0) begin
            failures++; $display("FAIL reset_data: got %h %h want 0 0", bus.data0, bus.data1);
        end
        checks++;
        if (bus.rom_enable !== 1'b0 || bus.rom_addr !== '0) begin
            failures++; $display("FAIL reset_rom: got en=%b addr=%h want 0 0", bus.rom_enable, bus.rom_addr);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE) begin
            failures++; $display("FAIL idle_no_req: got %b want %b", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_single_fetch();
        int ack_at, ack_cnt, en_cnt, other_cnt;
        logic [DW-1:0] d;
        run_access(1'b0, 30'h0, -1, '0, ack_at, ack_cnt, en_cnt, other_cnt, d);
        checks++;
        if (ack_at != 3) begin failures++; $display("FAIL fetch_latency: got %0d want 3", ack_at); end
        checks++;
        if (ack_cnt != 1) begin failures++; $display("FAIL fetch_ack_count: got %0d want 1", ack_cnt); end
        checks++;
        if (d !== 32'h4D525341) begin failures++; $display("FAIL fetch_data: got %h want 4d525341", d); end
        checks++;
        if (en_cnt != 2) begin failures++; $display("FAIL fetch_rom_enable_cycles: got %0d want 2", en_cnt); end
        checks++;
        if (other_cnt != 0) begin failures++; $display("FAIL fetch_ack1_quiet: got %0d want 0", other_cnt); end
    endtask

    task automatic test_single_load();
        int ack_at, ack_cnt, en_cnt, other_cnt;
        logic [DW-1:0] d;
        run_access(1'b1, 30'hF, -1, '0, ack_at, ack_cnt, en_cnt, other_cnt, d);
        checks++;
        if (ack_at != 3) begin failures++; $display("FAIL load_latency: got %0d want 3", ack_at); end
        checks++;
        if (d !== 32'hABCDEF00) begin failures++; $display("FAIL load_data: got %h want abcdef00", d); end
        checks++;
        if (other_cnt != 0) begin failures++; $display("FAIL load_ack0_quiet: got %0d want 0", other_cnt); end
        checks++;
        if (bus.data0 !== 32'h4D525341) begin
            failures++; $display("FAIL load_data0_held: got %h want 4d525341", bus.data0);
        end
    endtask

    task automatic test_reset_mid_access();
        int ack_at, ack_cnt, en_cnt, other_cnt, late_acks;
        logic [DW-1:0] d;
        @(posedge clk); #1 bus.req0 = 1'b1; bus.addr0 = 30'h17;  // granted this cycle
        @(posedge clk);                                         // ISSUE
        @(posedge clk); #2;                                     // CAPTURE
        checks++;
        if (dbg_state !== ST_CAPTURE) begin
            failures++; $display("FAIL abort_reached_capture: got %b want %b", dbg_state, ST_CAPTURE);
        end
        reset = 1'b0;
        bus.req0 = 1'b0;
        #1;
        checks++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.data0 !== '0 || bus.data1 !== '0) begin
            failures++;
            $display("FAIL abort_outputs_cleared: ack=%b%b data0=%h data1=%h want all 0",
                     bus.ack0, bus.ack1, bus.data0, bus.data1);
        end
        checks++;
        if (bus.rom_enable !== 1'b0 || bus.rom_addr !== '0 || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL abort_rom_cleared: en=%b addr=%h state=%b want 0 0 %b",
                     bus.rom_enable, bus.rom_addr, dbg_state, ST_IDLE);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        late_acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) late_acks++;
        end
        checks++;
        if (late_acks != 0) begin failures++; $display("FAIL abort_no_ack: got %0d acks want 0", late_acks); end
        run_access(1'b0, 30'hF, -1, '0, ack_at, ack_cnt, en_cnt, other_cnt, d);
        checks++;
        if (ack_at != 3 || d !== 32'hABCDEF00) begin
            failures++; $display("FAIL abort_rerequest: got ack_at=%0d data=%h want 3 abcdef00", ack_at, d);
        end
    endtask

    task automatic test_addr_change();
        int ack_at, ack_cnt, en_cnt, other_cnt;
        logic [DW-1:0] d;
        run_access(1'b0, 30'h0, 1, 30'hF, ack_at, ack_cnt, en_cnt, other_cnt, d);
        checks++;
        if (ack_at != 3 || d !== 32'h4D525341) begin
            failures++; $display("FAIL addr_change_latched: got ack_at=%0d data=%h want 3 4d525341", ack_at, d);
        end
        checks++;
        if (bus.rom_addr !== 30'h0) begin
            failures++; $display("FAIL addr_change_rom_addr: got %h want 0", bus.rom_addr);
        end
    endtask

    task automatic test_out_of_range();
        int ack_at, ack_cnt, en_cnt, other_cnt;
        logic [DW-1:0] d;
        run_access(1'b1, 30'h3FFFFFFF, -1, '0, ack_at, ack_cnt, en_cnt, other_cnt, d);
        checks++;
        if (ack_at != 3 || d !== 32'h0) begin
            failures++; $display("FAIL out_of_range: got ack_at=%0d data=%h want 3 00000000", ack_at, d);
        end
        checks++;
        if (bus.rom_addr !== 30'h3FFFFFFF) begin
            failures++; $display("FAIL out_of_range_rom_addr: got %h want 3fffffff", bus.rom_addr);
        end
    endtask

    task automatic test_contention();
        logic          a0 [17];
        logic          a1 [17];
        logic [DW-1:0] d0 [17];
        logic [DW-1:0] d1 [17];
        int            total;
        bit            exp_port;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.req0 = 1'b1; bus.addr0 = 30'h17;
                bus.req1 = 1'b1; bus.addr1 = 30'h1F;
            end
            if (i == 16) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            @(negedge clk);
            a0[i] = bus.ack0; a1[i] = bus.ack1; d0[i] = bus.data0; d1[i] = bus.data1;
        end
        total = 0;
        for (int i = 0; i < 17; i++) total += int'(a0[i] === 1'b1) + int'(a1[i] === 1'b1);
        checks++;
        if (total != 4) begin failures++; $display("FAIL contention_ack_total: got %0d want 4", total); end
        for (int n = 0; n < 4; n++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            exp_port = n[0];
`else
            exp_port = 1'b0;
`endif
            checks++;
            if (exp_port) begin
                if (a1[3 + 4*n] !== 1'b1 || a0[3 + 4*n] !== 1'b0 || d1[3 + 4*n] !== 32'h000000FB) begin
                    failures++;
                    $display("FAIL contention_ack%0d: got ack=%b%b data1=%h want port 1 data 000000fb",
                             n, a0[3 + 4*n], a1[3 + 4*n], d1[3 + 4*n]);
                end
            end else begin
                if (a0[3 + 4*n] !== 1'b1 || a1[3 + 4*n] !== 1'b0 || d0[3 + 4*n] !== 32'h01020304) begin
                    failures++;
                    $display("FAIL contention_ack%0d: got ack=%b%b data0=%h want port 0 data 01020304",
                             n, a0[3 + 4*n], a1[3 + 4*n], d0[3 + 4*n]);
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
            if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
            if ($urandom_range(0, 2) == 0) bus.addr0 = pick_addr();
            if ($urandom_range(0, 2) == 0) bus.addr1 = pick_addr();
        end
        @(posedge clk); #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL random_pending_acks: got %0d outstanding want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        reset     = 1'b0;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        test_reset();
        test_single_fetch();
        test_single_load();
        test_reset_mid_access();
        test_addr_change();
        test_out_of_range();
        test_contention();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
